// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 tables, shift schedule and types.
// DES_KEY_PARITY_CHK_EN adds the key byte-parity helper.
package des_pkg;

   localparam int HALF_W = 28;

   typedef logic [HALF_W-1:0] cd_half_t;
   typedef logic [47:0]       round_key_t;
   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   // Entries are DES bit numbers, bit 1 being the key MSB.
   localparam logic [5:0] PC1_TBL [0:55] = '{
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
      6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
      6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
      6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
      6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   localparam logic [5:0] PC2_TBL [0:47] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   localparam logic [1:0] SHIFT_TBL [0:15] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] cd;
      cd = 56'd0;
      for (int i = 0; i < 56; i++) begin
         cd[6'(55 - i)] = key[6'(7'd64 - 7'(PC1_TBL[6'(i)]))];
      end
      return cd;
   endfunction

   function automatic round_key_t pc2(input cd_half_t c, input cd_half_t d);
      logic [55:0] cd;
      round_key_t  rk;
      cd = {c, d};
      rk = 48'd0;
      for (int i = 0; i < 48; i++) begin
         rk[6'(47 - i)] = cd[6'(6'd56 - PC2_TBL[6'(i)])];
      end
      return rk;
   endfunction

`ifdef DES_KEY_PARITY_CHK_EN
   // A DES key byte is good when it carries odd parity.
   function automatic logic key_parity_bad(input logic [63:0] key);
      logic bad;
      bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
         bad = bad | ~(^key[6'(b * 8) +: 8]);
      end
      return bad;
   endfunction
`endif

endpackage

// File: rtl/des_cd_rotate.sv
// Rotates one 28-bit C or D half by one or two places, left or right.
module des_cd_rotate
   import des_pkg::*;
(
   input  cd_half_t half_i,
   input  logic     amt_two_i,
   input  logic     dir_right_i,
   output cd_half_t half_o
);

   // DES "left" moves bits towards DES bit 1, which is the MSB here.
   always_comb begin
      half_o = half_i;
      if (dir_right_i) begin
         if (amt_two_i) begin
            half_o = {half_i[1:0], half_i[27:2]};
         end else begin
            half_o = {half_i[0], half_i[27:1]};
         end
      end else begin
         if (amt_two_i) begin
            half_o = {half_i[25:0], half_i[27:26]};
         end else begin
            half_o = {half_i[26:0], half_i[27]};
         end
      end
   end

endmodule

// File: rtl/key_gen_rev.sv
// Sequential DES round-key generator emitting K16..K1 (decrypt) or K1..K16 (forward).
// Optional key byte-parity check enabled by defining DES_KEY_PARITY_CHK_EN.
module key_gen_rev
   import des_pkg::*;
#(
   parameter int KEY_W  = 64,
   parameter int RK_W   = 48,
   parameter int ROUNDS = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] key_in,
   input  logic             key_load,
   input  logic             decrypt,
   input  logic             abort,
   output logic             load_rdy,
   output logic [RK_W-1:0]  rkey,
   output logic [3:0]       rkey_idx,
   output logic             rkey_valid,
   input  logic             rkey_ready,
   output logic             done,
   output logic             parity_err
);

   state_t      state_q, state_d;
   cd_half_t    c_q, c_d, d_q, d_d;
   logic [3:0]  count_q, count_d;
   logic        mode_q, mode_d;
   logic        done_q, done_d;

   logic [55:0] pc1_s;
   cd_half_t    c_src_s, d_src_s, c_rot_s, d_rot_s;
   logic [3:0]  shift_idx_s;
   logic        rot_two_s, rot_right_s, last_s;

   assign pc1_s  = pc1(key_in);
   assign last_s = (count_q == 4'(ROUNDS - 1));

   // In IDLE the rotators pre-shift the fresh PC-1 state for forward mode.
   always_comb begin
      c_src_s     = c_q;
      d_src_s     = d_q;
      rot_right_s = mode_q;
      shift_idx_s = count_q + 4'd1;
      if (state_q == IDLE) begin
         c_src_s     = pc1_s[55:28];
         d_src_s     = pc1_s[27:0];
         rot_right_s = 1'b0;
         shift_idx_s = 4'd0;
      end else if (mode_q) begin
         shift_idx_s = 4'd15 - count_q;
      end else begin
         shift_idx_s = count_q + 4'd1;
      end
      rot_two_s = (SHIFT_TBL[shift_idx_s] == 2'd2);
   end

   des_cd_rotate u_rot_c (
      .half_i      (c_src_s),
      .amt_two_i   (rot_two_s),
      .dir_right_i (rot_right_s),
      .half_o      (c_rot_s)
   );

   des_cd_rotate u_rot_d (
      .half_i      (d_src_s),
      .amt_two_i   (rot_two_s),
      .dir_right_i (rot_right_s),
      .half_o      (d_rot_s)
   );

   // Next-state logic: load, handshake stepping and abort (abort wins).
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      count_d = count_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_load) begin
               state_d = EMIT;
               mode_d  = decrypt;
               count_d = 4'd0;
               if (decrypt) begin
                  c_d = pc1_s[55:28];
                  d_d = pc1_s[27:0];
               end else begin
                  c_d = c_rot_s;
                  d_d = d_rot_s;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (rkey_ready) begin
               if (last_s) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  count_d = count_q + 4'd1;
                  c_d     = c_rot_s;
                  d_d     = d_rot_s;
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         c_q     <= 28'd0;
         d_q     <= 28'd0;
         count_q <= 4'd0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

`ifdef DES_KEY_PARITY_CHK_EN
   logic parity_q, parity_d;

   // Parity status is refreshed only by an accepted load.
   always_comb begin
      if ((state_q == IDLE) && key_load) begin
         parity_d = key_parity_bad(key_in);
      end else begin
         parity_d = parity_q;
      end
   end

   // Parity status register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity_err = parity_q;
`else
   assign parity_err = 1'b0;
`endif

   assign rkey       = pc2(c_q, d_q);
   assign rkey_idx   = mode_q ? (4'd15 - count_q) : count_q;
   assign rkey_valid = (state_q == EMIT);
   assign load_rdy   = (state_q == IDLE);
   assign done       = done_q;

endmodule
